lfsr_range_sampler: RTL and testbench
=====================================

LFSR_RANGE_SAMPLER -- requirements
Module: lfsr_range_sampler

Interface
REQ-001 Parameter: MAX_TRIES, default 8, number of LFSR candidates examined per request before fallback; legal range 1..15.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 req_i  in  1  request one bounded random sample; sampled only in IDLE.
REQ-005 limit_i  in  8  exclusive upper bound; captured on the accepting edge.
REQ-006 lfsr_val_i  in  8  current value of the upstream 8-bit LFSR register.
REQ-007 lfsr_step_o  out  1  one-cycle pulse advancing the LFSR; drives the LFSR start input.
REQ-008 busy_o  out  1  high in every state except IDLE.
REQ-009 valid_o  out  1  one-cycle pulse; sample_o, err_o and fallback_o are valid this cycle.
REQ-010 sample_o  out  8  result, uniform in [0, limit-1] on acceptance.
REQ-011 err_o  out  1  request had limit_i == 0.
REQ-012 fallback_o  out  1  result produced by the fallback path, not by acceptance.

Function
REQ-013 FSM states IDLE, STEP, CHECK, DONE; encoding is free.
REQ-014 IDLE: req_i=1 with limit_i != 0 -> capture limit_r, mask_r, clear try counter, go STEP.
REQ-015 IDLE: req_i=1 with limit_i == 0 -> go DONE with sample=0, err=1, fallback=0; no step pulse.
REQ-016 mask_r = (limit_i-1) with all bits below its MSB set; limit_i=1 -> mask 0x00, limit_i=200 -> 0xFF, limit_i=5 -> 0x07.
REQ-017 STEP: lfsr_step_o=1 for exactly this cycle, then go CHECK; lfsr_step_o is 0 in all other states.
REQ-018 CHECK: candidate = lfsr_val_i & mask_r (post-step value, since the LFSR is registered).
REQ-019 CHECK, candidate < limit_r -> sample=candidate, fallback=0, go DONE.
REQ-020 CHECK, candidate >= limit_r, tries+1 < MAX_TRIES -> increment tries, go STEP.
REQ-021 CHECK, candidate >= limit_r, tries+1 == MAX_TRIES -> sample=candidate-limit_r (8-bit, always < limit_r because mask_r < 2*limit_r), fallback=1, go DONE.
REQ-022 DONE: valid_o=1 for one cycle, then go IDLE; busy_o=0 from the IDLE cycle onward.
REQ-023 Latency: k candidates examined -> valid_o high 1+2k clocks after the accepting edge (first-try accept = 3).
REQ-024 Step pulses per request equal the number of candidates examined; k <= MAX_TRIES.
REQ-025 req_i is ignored while busy_o=1; no queuing; a request held high is re-accepted in the IDLE cycle after DONE.
REQ-026 limit_i changes after acceptance do not affect the request in progress.
REQ-027 sample_o, err_o and fallback_o hold their values until the next DONE.
REQ-028 Try counter width is 4 bits; it never wraps because MAX_TRIES <= 15.

Reset
REQ-029 rst_ni low -> immediately IDLE; sample_o=0, valid_o=0, busy_o=0, err_o=0, fallback_o=0, lfsr_step_o=0, tries=0.
REQ-030 Reset asserted mid-request aborts it: no valid_o pulse and no further step pulses after release.
REQ-031 The first request is accepted on the first rising edge after rst_ni deasserts.

Verification
REQ-032 The bench shall cover: limit_i=0, req pulse -> valid at +1 (DONE), err_o=1, sample_o=0x00, zero step pulses.
REQ-033 The bench shall cover: limit_i=1, any LFSR value -> one step pulse, valid at +3, sample_o=0x00, fallback_o=0.
REQ-034 The bench shall cover: limit_i=200, post-step lfsr_val_i=0x57 -> valid at +3, sample_o=0x57.
REQ-035 The bench shall cover: limit_i=5, post-step values 0x06, 0x0F, 0x23 -> two rejects, three step pulses, valid at +7, sample_o=3.
REQ-036 The bench shall cover: MAX_TRIES=2, limit_i=5, lfsr_val_i stuck at 0x06 -> two step pulses, valid at +5, sample_o=1, fallback_o=1.
REQ-037 The bench shall cover: rst_ni pulsed low during CHECK -> all outputs 0 at once, no valid_o, next request completes normally.

Source files
------------

// File: rtl/lfsr_range_sampler.sv
// ============================================================================
// lfsr_range_sampler : bounded uniform sample from an external 8-bit LFSR
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr_range_sampler #(
  parameter int MAX_TRIES = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic [7:0] limit_i,
  input  logic [7:0] lfsr_val_i,
  output logic       lfsr_step_o,
  output logic       busy_o,
  output logic       valid_o,
  output logic [7:0] sample_o,
  output logic       err_o,
  output logic       fallback_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_last_try = 4'(MAX_TRIES - 1);

  state_t     state_q, state_d;
  logic [7:0] limit_q, limit_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] sample_q, sample_d;
  logic [3:0] tries_q, tries_d;
  logic       err_q, err_d;
  logic       fallback_q, fallback_d;

  logic [7:0] limit_m1;
  logic [7:0] limit_mask;
  logic [7:0] candidate;

  // Smear the MSB of (limit-1) downwards: smallest all-ones mask covering limit-1.
  always_comb begin
    limit_m1   = limit_i - 8'd1;
    limit_mask = limit_m1 | (limit_m1 >> 1);
    limit_mask = limit_mask | (limit_mask >> 2);
    limit_mask = limit_mask | (limit_mask >> 4);
  end

  // The LFSR is registered, so in CHECK it already shows the post-step value.
  assign candidate = lfsr_val_i & mask_q;

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    mask_d     = mask_q;
    sample_d   = sample_q;
    tries_d    = tries_q;
    err_d      = err_q;
    fallback_d = fallback_q;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (limit_i == 8'd0) begin
            sample_d   = 8'd0;
            err_d      = 1'b1;
            fallback_d = 1'b0;
            state_d    = DONE;
          end else begin
            limit_d = limit_i;
            mask_d  = limit_mask;
            tries_d = 4'd0;
            state_d = STEP;
          end
        end
      end
      STEP: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (candidate < limit_q) begin
          sample_d   = candidate;
          err_d      = 1'b0;
          fallback_d = 1'b0;
          state_d    = DONE;
        end else if (tries_q == c_last_try) begin
          // mask < 2*limit, so this difference always lands inside [0, limit-1].
          sample_d   = candidate - limit_q;
          err_d      = 1'b0;
          fallback_d = 1'b1;
          state_d    = DONE;
        end else begin
          tries_d = tries_q + 4'd1;
          state_d = STEP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      limit_q    <= 8'd0;
      mask_q     <= 8'd0;
      sample_q   <= 8'd0;
      tries_q    <= 4'd0;
      err_q      <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      mask_q     <= mask_d;
      sample_q   <= sample_d;
      tries_q    <= tries_d;
      err_q      <= err_d;
      fallback_q <= fallback_d;
    end
  end

  assign lfsr_step_o = (state_q == STEP);
  assign busy_o      = (state_q != IDLE);
  assign valid_o     = (state_q == DONE);
  assign sample_o    = sample_q;
  assign err_o       = err_q;
  assign fallback_o  = fallback_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_range_sampler.sv
// ============================================================================
// tb_lfsr_range_sampler : directed table, corner sequences and random requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_range_sampler;

  localparam int MT_A = 8;
  localparam int MT_B = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       req_a, req_b;
  logic [7:0] limit_a, limit_b;
  logic [7:0] lfsr_a, lfsr_b;
  logic       step_a, busy_a, valid_a, err_a, fb_a;
  logic       step_b, busy_b, valid_b, err_b, fb_b;
  logic [7:0] sample_a, sample_b;

  always #5 clk_i = ~clk_i;

  lfsr_range_sampler #(.MAX_TRIES(MT_A)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_a), .limit_i(limit_a),
    .lfsr_val_i(lfsr_a), .lfsr_step_o(step_a), .busy_o(busy_a),
    .valid_o(valid_a), .sample_o(sample_a), .err_o(err_a), .fallback_o(fb_a)
  );

  lfsr_range_sampler #(.MAX_TRIES(MT_B)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_b), .limit_i(limit_b),
    .lfsr_val_i(lfsr_b), .lfsr_step_o(step_b), .busy_o(busy_b),
    .valid_o(valid_b), .sample_o(sample_b), .err_o(err_b), .fallback_o(fb_b)
  );

  int sel = 0;
  logic       mon_step, mon_busy, mon_valid, mon_err, mon_fb;
  logic [7:0] mon_sample;
  assign mon_step   = (sel == 1) ? step_b   : step_a;
  assign mon_busy   = (sel == 1) ? busy_b   : busy_a;
  assign mon_valid  = (sel == 1) ? valid_b  : valid_a;
  assign mon_sample = (sel == 1) ? sample_b : sample_a;
  assign mon_err    = (sel == 1) ? err_b    : err_a;
  assign mon_fb     = (sel == 1) ? fb_b     : fb_a;

  // Upstream registered LFSR for dut_a: scripted values first, free-running after.
  logic [7:0] script[$];
  always @(posedge clk_i) begin : lfsr_model
    logic [7:0] nv;
    if (step_a) begin
      if (script.size() > 0) nv = script.pop_front();
      else nv = {lfsr_a[6:0], lfsr_a[7] ^ lfsr_a[5] ^ lfsr_a[4] ^ lfsr_a[3]};
      lfsr_a <= nv;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request on the selected DUT; returns observed latency/steps/outputs.
  task automatic run_req(input logic [7:0] lim, output int lat, output int steps,
                         output logic [7:0] smp, output logic e, output logic f);
    @(negedge clk_i);
    chk("idle_before_req", {31'd0, mon_busy}, 32'd0);
    if (sel == 1) begin req_b = 1'b1; limit_b = lim; end
    else begin req_a = 1'b1; limit_a = lim; end
    @(negedge clk_i);
    req_a = 1'b0; req_b = 1'b0;
    limit_a = 8'($urandom); limit_b = 8'($urandom);
    lat = -1; steps = 0; smp = 8'd0; e = 1'b0; f = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (mon_step) steps++;
      if (mon_valid) begin
        lat = n; smp = mon_sample; e = mon_err; f = mon_fb;
        break;
      end
      @(negedge clk_i);
    end
    @(negedge clk_i);
  endtask

  task automatic check_result(input string tag, input int lat, input int steps,
                              input logic [7:0] smp, input logic e, input logic f,
                              input int x_lat, input int x_steps,
                              input logic [7:0] x_smp, input logic x_e, input logic x_f);
    chk({tag, "_latency"}, lat, x_lat);
    chk({tag, "_steps"}, steps, x_steps);
    chk({tag, "_sample"}, {24'd0, smp}, {24'd0, x_smp});
    chk({tag, "_err"}, {31'd0, e}, {31'd0, x_e});
    chk({tag, "_fallback"}, {31'd0, f}, {31'd0, x_f});
    chk({tag, "_hold_valid_low"}, {31'd0, mon_valid}, 32'd0);
    chk({tag, "_hold_sample"}, {24'd0, mon_sample}, {24'd0, x_smp});
  endtask

  typedef struct {
    logic [7:0] limit;
    int         nvals;
    logic [7:0] v0, v1, v2;
    int         lat;
    int         steps;
    logic [7:0] smp;
    logic       err;
    logic       fb;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         lat, steps, x_lat, x_steps, k, lim, mask, p;
    logic [7:0] smp, x_smp, c;
    logic       e, f, x_e, x_f, force_rej;
    logic [7:0] vals[MT_A];
    int         seen_valid, seen_step;

    tbl[0] = '{8'd0,   0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'd1,   1, 8'hA5, 8'h00, 8'h00, 3, 1, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'd200, 1, 8'h57, 8'h00, 8'h00, 3, 1, 8'h57, 1'b0, 1'b0};
    tbl[3] = '{8'd5,   3, 8'h06, 8'h0F, 8'h23, 7, 3, 8'h03, 1'b0, 1'b0};
    tbl[4] = '{8'd128, 1, 8'hFF, 8'h00, 8'h00, 3, 1, 8'h7F, 1'b0, 1'b0};
    tbl[5] = '{8'd255, 2, 8'hFF, 8'h10, 8'h00, 5, 2, 8'h10, 1'b0, 1'b0};

    rst_ni = 1'b0; req_a = 1'b0; req_b = 1'b0;
    limit_a = 8'd0; limit_b = 8'd0; lfsr_a = 8'h01; lfsr_b = 8'h06;
    #12;
    chk("rst_busy",   {31'd0, busy_a},  32'd0);
    chk("rst_valid",  {31'd0, valid_a}, 32'd0);
    chk("rst_step",   {31'd0, step_a},  32'd0);
    chk("rst_sample", {24'd0, sample_a}, 32'd0);
    chk("rst_err",    {31'd0, err_a},   32'd0);
    chk("rst_fb",     {31'd0, fb_a},    32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) begin
      script.delete();
      if (tbl[i].nvals > 0) script.push_back(tbl[i].v0);
      if (tbl[i].nvals > 1) script.push_back(tbl[i].v1);
      if (tbl[i].nvals > 2) script.push_back(tbl[i].v2);
      run_req(tbl[i].limit, lat, steps, smp, e, f);
      check_result($sformatf("tbl%0d", i), lat, steps, smp, e, f,
                   tbl[i].lat, tbl[i].steps, tbl[i].smp, tbl[i].err, tbl[i].fb);
    end

    // Reset in the middle of a request (dut_a currently holds sample 0x10).
    script.delete();
    for (int i = 0; i < MT_A; i++) script.push_back(8'h06);
    @(negedge clk_i);
    req_a = 1'b1; limit_a = 8'd5;
    @(negedge clk_i);
    req_a = 1'b0;
    chk("abort_step_pulse", {31'd0, step_a}, 32'd1);
    @(negedge clk_i);
    chk("abort_in_check_busy", {31'd0, busy_a}, 32'd1);
    chk("abort_pre_sample", {24'd0, sample_a}, 32'h10);
    rst_ni = 1'b0;
    #1;
    chk("abort_busy",   {31'd0, busy_a},  32'd0);
    chk("abort_valid",  {31'd0, valid_a}, 32'd0);
    chk("abort_step",   {31'd0, step_a},  32'd0);
    chk("abort_sample", {24'd0, sample_a}, 32'd0);
    chk("abort_err",    {31'd0, err_a},   32'd0);
    chk("abort_fb",     {31'd0, fb_a},    32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen_valid = 0; seen_step = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_i);
      if (valid_a) seen_valid++;
      if (step_a) seen_step++;
    end
    chk("abort_no_valid_after", seen_valid, 0);
    chk("abort_no_step_after", seen_step, 0);
    script.delete();
    script.push_back(8'h57);
    run_req(8'd200, lat, steps, smp, e, f);
    check_result("after_abort", lat, steps, smp, e, f, 3, 1, 8'h57, 1'b0, 1'b0);

    // Request held high is re-accepted in the IDLE cycle after DONE.
    @(negedge clk_i);
    req_a = 1'b1; limit_a = 8'd0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk_i);
      chk($sformatf("held_req_valid_c%0d", n), {31'd0, valid_a}, (n == 1 || n == 3) ? 32'd1 : 32'd0);
      chk($sformatf("held_req_busy_c%0d", n), {31'd0, busy_a}, (n == 1 || n == 3) ? 32'd1 : 32'd0);
      if (n == 3) req_a = 1'b0;
    end

    // MAX_TRIES=2 instance with its LFSR stuck at 0x06.
    sel = 1;
    run_req(8'd5, lat, steps, smp, e, f);
    check_result("mt2_fallback", lat, steps, smp, e, f, 5, 2, 8'h01, 1'b0, 1'b1);
    run_req(8'd3, lat, steps, smp, e, f);
    check_result("mt2_accept", lat, steps, smp, e, f, 3, 1, 8'h02, 1'b0, 1'b0);
    sel = 0;

    // Random requests against a rejection-sampling reference.
    for (int r = 0; r < 40; r++) begin
      lim = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
      p = 1;
      while (p < lim) p = p * 2;
      mask = p - 1;
      force_rej = ($urandom_range(0, 3) == 0);
      script.delete();
      for (int t = 0; t < MT_A; t++) begin
        vals[t] = 8'($urandom);
        if (force_rej && lim > 0 && mask >= lim)
          vals[t] = (vals[t] & ~8'(mask)) | 8'($urandom_range(lim, mask));
        script.push_back(vals[t]);
      end
      x_smp = 8'd0; x_e = 1'b0; x_f = 1'b0; k = 0;
      if (lim == 0) begin
        x_e = 1'b1;
      end else begin
        for (int t = 0; t < MT_A; t++) begin
          k = t + 1;
          c = vals[t] & 8'(mask);
          if (int'(c) < lim) begin
            x_smp = c;
            break;
          end else if (t == MT_A - 1) begin
            x_smp = 8'(int'(c) - lim);
            x_f = 1'b1;
          end
        end
      end
      x_lat = 1 + 2 * k;
      x_steps = k;
      run_req(8'(lim), lat, steps, smp, e, f);
      check_result($sformatf("rnd%0d_lim%0d", r, lim), lat, steps, smp, e, f,
                   x_lat, x_steps, x_smp, x_e, x_f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
